// File: rtl/align_shift_pipe.sv
// Two-stage alignment shifter: the beat is captured, then its significand is right-shifted by |EXP_DIFF|.
// Latency is 2 cycles and up to two beats are held under OUT_READY backpressure. Define ALIGN_STICKY_EN to build STICKY.
module align_shift_pipe #(
  parameter int FRAC_W = 4,
  parameter int EXP_W  = 5,
  parameter int GRD_W  = 1,
  localparam int SIG_W = FRAC_W + 1 + GRD_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [EXP_W-1:0]  EXP_DIFF,
  input  logic [FRAC_W-1:0] S_FRAC,
  input  logic              HIDDEN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [SIG_W-1:0]  SHIFT_FRAC,
  output logic              STICKY,
  output logic              NEG
);

  logic             v1_q, v2_q;
  logic             neg1_q, neg2_q;
  logic [EXP_W-1:0] mag1_q, mag1_d;
  logic [SIG_W-1:0] sig1_q, sig1_d;
  logic [SIG_W-1:0] shift_q, shift_d;
  logic             adv1, adv2, big;

  assign adv2       = !v2_q || OUT_READY;
  assign adv1       = !v1_q || adv2;
  assign IN_READY   = adv1;
  assign OUT_VALID  = v2_q;
  assign SHIFT_FRAC = shift_q;
  assign NEG        = neg2_q;

  // Two's-complement negate; the most negative code maps onto 2^(EXP_W-1) as an unsigned magnitude.
  assign mag1_d  = EXP_DIFF[EXP_W-1] ? (~EXP_DIFF + {{(EXP_W-1){1'b0}}, 1'b1}) : EXP_DIFF;
  assign sig1_d  = {HIDDEN, S_FRAC, {GRD_W{1'b0}}};
  assign big     = 32'(mag1_q) >= SIG_W;
  assign shift_d = big ? '0 : (sig1_q >> mag1_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= IN_VALID;
      if (adv2) v2_q <= v1_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      neg1_q <= 1'b0;
      mag1_q <= '0;
      sig1_q <= '0;
    end else if (adv1 && IN_VALID) begin
      neg1_q <= EXP_DIFF[EXP_W-1];
      mag1_q <= mag1_d;
      sig1_q <= sig1_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      neg2_q  <= 1'b0;
      shift_q <= '0;
    end else if (adv2 && v1_q) begin
      neg2_q  <= neg1_q;
      shift_q <= shift_d;
    end
  end

`ifdef ALIGN_STICKY_EN
  logic             sticky_q, sticky_d;
  logic [SIG_W-1:0] mask;

  // Mask selects the bits that fall off the bottom of the shift.
  assign mask     = big ? '1 : ((SIG_W'(1) << mag1_q) - SIG_W'(1));
  assign sticky_d = |(sig1_q & mask);
  assign STICKY   = sticky_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              sticky_q <= 1'b0;
    else if (adv2 && v1_q)   sticky_q <= sticky_d;
  end
`else
  assign STICKY = 1'b0;
`endif

endmodule

// File: tb/tb_align_shift_pipe.sv
// Bench for align_shift_pipe: directed test-plan steps then random traffic, scored against an arithmetic model.
module tb_align_shift_pipe;

  localparam int FRAC_W = 4;
  localparam int EXP_W  = 5;
  localparam int GRD_W  = 1;
  localparam int SIG_W  = FRAC_W + 1 + GRD_W;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              IN_VALID;
  logic              IN_READY;
  logic [EXP_W-1:0]  EXP_DIFF;
  logic [FRAC_W-1:0] S_FRAC;
  logic              HIDDEN;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [SIG_W-1:0]  SHIFT_FRAC;
  logic              STICKY;
  logic              NEG;

  align_shift_pipe #(.FRAC_W(FRAC_W), .EXP_W(EXP_W), .GRD_W(GRD_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .EXP_DIFF(EXP_DIFF), .S_FRAC(S_FRAC), .HIDDEN(HIDDEN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SHIFT_FRAC(SHIFT_FRAC), .STICKY(STICKY), .NEG(NEG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int               acc;
    logic [SIG_W-1:0] sf;
    logic             st;
    logic             ng;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_acc  = 0;
  int   n_out  = 0;

  // Reference: treat the significand as an integer and divide by 2^|diff|; the remainder is the sticky.
  function automatic exp_t model(input logic [EXP_W-1:0] d, input logic [FRAC_W-1:0] f, input logic h);
    exp_t   e;
    longint sig, p;
    int     dv, mag;
    sig = ((longint'(h) << FRAC_W) + longint'(f)) * (longint'(1) << GRD_W);
    dv  = int'($signed(d));
    mag = (dv < 0) ? -dv : dv;
    p   = 1;
    for (int i = 0; i < mag; i++) p = p * 2;
    e.acc = 0;
    e.sf  = SIG_W'(sig / p);
`ifdef ALIGN_STICKY_EN
    e.st  = (sig % p) != 0;
`else
    e.st  = 1'b0;
`endif
    e.ng  = dv < 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check outputs at the negedge, update the model, then return 1 time unit after the posedge.
  task automatic step();
    logic exp_rdy, exp_vld;
    exp_t e;
    @(negedge CLK);
    exp_rdy = (q.size() < 2) || OUT_READY;
    exp_vld = (q.size() > 0) && (cyc >= q[0].acc + 1);
    chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
    chk("out_valid", 32'(OUT_VALID), 32'(exp_vld));
    if (exp_vld) begin
      chk("shift_frac", 32'(SHIFT_FRAC), 32'(q[0].sf));
      chk("sticky", 32'(STICKY), 32'(q[0].st));
      chk("neg", 32'(NEG), 32'(q[0].ng));
    end
    if (OUT_VALID && OUT_READY) n_out++;
    if (exp_vld && OUT_READY) void'(q.pop_front());
    if (IN_VALID && exp_rdy) begin
      e = model(EXP_DIFF, S_FRAC, HIDDEN);
      e.acc = cyc + 1;
      q.push_back(e);
      n_acc++;
    end
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input logic [EXP_W-1:0] d, input logic [FRAC_W-1:0] f, input logic h);
    IN_VALID = v;
    EXP_DIFF = d;
    S_FRAC   = f;
    HIDDEN   = h;
  endtask

  task automatic single(input logic [EXP_W-1:0] d, input logic [FRAC_W-1:0] f, input logic h);
    drive(1'b1, d, f, h);
    step();
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) step();
  endtask

  initial begin
    RST_N     = 1'b0;
    OUT_READY = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    #12;
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_shift_frac", 32'(SHIFT_FRAC), 32'd0);
    chk("rst_sticky", 32'(STICKY), 32'd0);
    chk("rst_neg", 32'(NEG), 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step();

    // Isolated beats from the test plan, SIG = 6'b110100 unless noted.
    single(5'd0,     4'b1010, 1'b1);
    single(5'd2,     4'b1010, 1'b1);
    single(5'd3,     4'b1010, 1'b1);
    single(5'b11101, 4'b1010, 1'b1);
    single(5'b10000, 4'b1010, 1'b1);
    single(5'd7,     4'b0000, 1'b0);
    single(5'd6,     4'b1111, 1'b1);
    single(5'b11010, 4'b0001, 1'b0);

    // Back-to-back shifts 0..3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, EXP_W'(i), 4'b1010, 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) step();

    // Backpressure: stream while OUT_READY is low for 5 cycles, then drain.
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, EXP_W'(i + 1), 4'b0110, 1'b1);
      step();
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, EXP_W'(5'b11111 - i), 4'b1001, 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    repeat (4) step();

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      OUT_READY = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 2) != 0), EXP_W'($urandom), FRAC_W'($urandom), 1'($urandom));
      step();
    end
    OUT_READY = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (4) step();
    chk("beat_count", 32'(n_out), 32'(n_acc));

    // Asynchronous reset with two beats held.
    OUT_READY = 1'b0;
    drive(1'b1, 5'd1, 4'b1010, 1'b1);
    step();
    drive(1'b1, 5'd2, 4'b1010, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("held_out_valid", 32'(OUT_VALID), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("arst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("arst_shift_frac", 32'(SHIFT_FRAC), 32'd0);
    q.delete();
    #2;
    RST_N = 1'b1;
    OUT_READY = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/align_shift_pipe.md
Name: align_shift_pipe

Overview:
- Pipelined, parametrised mantissa alignment shifter for the floating-point add path.
- Takes a signed exponent difference and a fraction, and builds the extended significand {hidden, fraction, guard zeros}.
- Right-shifts that significand by |difference| and, optionally, produces a sticky bit.
- Two-stage valid/ready pipeline sitting between exponent compare and the significand adder.

Parameters:
- FRAC_W, 4, stored fraction width.
- EXP_W, 5, width of the signed two's-complement exponent difference.
- GRD_W, 1, number of guard zeros appended below the fraction.
- Derived: SIG_W = FRAC_W+1+GRD_W.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  block can accept a beat this cycle.
- EXP_DIFF  in  EXP_W  signed exponent difference.
- S_FRAC  in  FRAC_W  fraction of the smaller operand.
- HIDDEN  in  1  implicit leading bit (0 = denormal).
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts the result.
- SHIFT_FRAC  out  SIG_W  aligned significand.
- STICKY  out  1  OR of all bits shifted out.
- NEG  out  1  EXP_DIFF was negative.

Behaviour:
- Reset (async, RST_N=0): all stage valids are cleared, so OUT_VALID=0. Data registers SHIFT_FRAC=0, STICKY=0, NEG=0. IN_READY=1 after reset deasserts.
- Stage 1 (capture, on IN_VALID & IN_READY):
  - NEG1 = EXP_DIFF[EXP_W-1].
  - MAG1 = |EXP_DIFF|, EXP_W bits, unsigned. The most negative code 100..0 gives MAG1 = 2^(EXP_W-1); no overflow.
  - SIG1 = {HIDDEN, S_FRAC, GRD_W'b0}.
- Stage 2 (capture from stage 1 when stage 2 advances):
  - SHIFT_FRAC = SIG1 >> MAG1 (logical, zero fill).
  - If MAG1 >= SIG_W: SHIFT_FRAC = 0.
  - STICKY = OR of the bits of SIG1 below position MAG1. If MAG1 >= SIG_W, this is OR of all of SIG1.
  - NEG passes through.
- Handshake:
  - adv2 = !V2 | OUT_READY.
  - adv1 = !V1 | adv2.
  - IN_READY = adv1. This is a combinational path from OUT_READY.
  - V1 loads IN_VALID when adv1; V2 loads V1 when adv2.
- Latency and throughput:
  - Latency is 2 cycles from accept to OUT_VALID when unstalled.
  - Throughput is 1 beat/cycle with OUT_READY held high.
- Stall: with OUT_VALID=1 and OUT_READY=0, SHIFT_FRAC, STICKY and NEG stay stable. Up to 2 beats are held and none are lost or duplicated.
- Simultaneous accept and drain: a full pipeline with OUT_READY=1 accepts a new beat in the same cycle it emits one.
- Ordering: beats exit in acceptance order.
- Reset mid-operation: in-flight beats are discarded and no output beat follows reset.
- Data registers update only on their stage advance with valid data; they are not cleared when a stage empties.

Optional Feature:
- Macro: ALIGN_STICKY_EN.
- Defined: STICKY is computed as above.
- Undefined: STICKY is tied to 0 and no sticky logic is built; all other behaviour is unchanged.

Test Plan:
(All cases use default parameters, so SIG_W=6, with S_FRAC=4'b1010, HIDDEN=1 (SIG=6'b110100) and OUT_READY=1 unless noted.)
- EXP_DIFF=0 -> after 2 cycles: SHIFT_FRAC=6'b110100, STICKY=0, NEG=0.
- EXP_DIFF=2 -> SHIFT_FRAC=6'b001101, STICKY=0. EXP_DIFF=3 -> SHIFT_FRAC=6'b000110, STICKY=1 (ALIGN_STICKY_EN defined; 0 when undefined).
- EXP_DIFF=5'b11101 (-3) -> SHIFT_FRAC=6'b000110, STICKY=1, NEG=1. EXP_DIFF=5'b10000 (-16) -> SHIFT_FRAC=0, STICKY=1, NEG=1. HIDDEN=0, S_FRAC=0, EXP_DIFF=7 -> SHIFT_FRAC=0, STICKY=0.
- Back-to-back EXP_DIFF=0,1,2,3 on consecutive cycles -> four consecutive OUT_VALID beats, in order, with SHIFT_FRAC 110100, 011010, 001101, 000110.
- Backpressure: OUT_READY=0 for 5 cycles while streaming -> IN_READY drops once 2 beats are held and outputs stay stable. Releasing OUT_READY drains both beats in order with no loss or duplication.
- Drive RST_N low asynchronously while 2 beats are in flight -> OUT_VALID=0 immediately, SHIFT_FRAC=0, and no stale beat appears after release.
